// File: rtl/restoring_div_nbit_seq.sv
// restoring_div_nbit_seq: unsigned N-bit sequential restoring divider, one quotient bit per clock
// with a start/busy/done handshake and a divide-by-zero flag.
module restoring_div_nbit_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quot,
    output logic [N-1:0] rem,
    output logic         dbz
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d, qr_q, qr_d, vr_q, vr_d, quot_q, quot_d, rem_q, rem_d;
    logic [N:0]    a_sh, t;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d, dbz_q, dbz_d;

    // The partial remainder always stays below the divisor, so N bits hold it between steps.
    always_comb begin
        a_sh    = {a_q, qr_q[N-1]};
        t       = a_sh - {1'b0, vr_q};
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        vr_d    = vr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && divisor != '0) begin
                    state_d = RUN;
                    a_d     = '0;
                    qr_d    = dividend;
                    vr_d    = divisor;
                    cnt_d   = CW'(N);
                end else if (start) begin
                    quot_d = '1;
                    rem_d  = dividend;
                    dbz_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            RUN: begin
                a_d   = t[N] ? a_sh[N-1:0] : t[N-1:0];
                qr_d  = {qr_q[N-2:0], ~t[N]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    quot_d  = qr_d;
                    rem_d   = a_d;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            qr_q    <= '0;
            vr_q    <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            vr_q    <= vr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;
    assign dbz  = dbz_q;
endmodule

// File: tb/tb_restoring_div_nbit_seq.sv
// tb_restoring_div_nbit_seq: checks an N=8 and an N=4 divider against fixed vectors,
// handshake corner cases, random operands and an exhaustive 4-bit sweep.
module tb_restoring_div_nbit_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, busy8, done8, dbz8;
    logic [7:0] dvd8, dvs8, quot8, rem8;
    logic       start4, busy4, done4, dbz4;
    logic [3:0] dvd4, dvs4, quot4, rem4;
    int         checks = 0, errors = 0, stab_bad = 0;

    always #5 clk = ~clk;

    restoring_div_nbit_seq #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quot(quot8), .rem(rem8), .dbz(dbz8)
    );

    restoring_div_nbit_seq #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividend(dvd4), .divisor(dvs4),
        .busy(busy4), .done(done4), .quot(quot4), .rem(rem4), .dbz(dbz4)
    );

    typedef struct {
        logic [7:0] a, b, q, r;
        logic       z;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer division, all-ones quotient and dividend as remainder on /0.
    function automatic logic [7:0] model_q(input int w, input int a, input int b);
        return (b == 0) ? 8'((1 << w) - 1) : 8'(a / b);
    endfunction

    function automatic logic [7:0] model_r(input int a, input int b);
        return (b == 0) ? 8'(a) : 8'(a % b);
    endfunction

    // Caller is at a negedge; returns at the negedge just after the sampling edge E0.
    task automatic start_op(input bit w4, input logic [7:0] a, input logic [7:0] b);
        if (w4) begin start4 = 1'b1; dvd4 = a[3:0]; dvs4 = b[3:0]; end
        else begin start8 = 1'b1; dvd8 = a; dvs8 = b; end
        @(posedge clk);
        #1 start4 = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
    endtask

    // k counts edges after E0 at which done is first seen; bc counts busy cycles observed.
    task automatic wait_done(input bit w4, input int k0, output logic [7:0] q, output logic [7:0] r,
                             output logic z, output int k, output int bc);
        logic [7:0] q0, r0;
        q0 = w4 ? {4'b0, quot4} : quot8;
        r0 = w4 ? {4'b0, rem4} : rem8;
        k  = k0;
        bc = 0;
        while (!(w4 ? done4 : done8) && k < 40) begin
            if (w4 ? busy4 : busy8) begin
                bc++;
                if ((w4 ? {4'b0, quot4} : quot8) != q0 || (w4 ? {4'b0, rem4} : rem8) != r0) stab_bad++;
            end
            @(negedge clk);
            k++;
        end
        q = w4 ? {4'b0, quot4} : quot8;
        r = w4 ? {4'b0, rem4} : rem8;
        z = w4 ? dbz4 : dbz8;
    endtask

    task automatic run_div(input bit w4, input logic [7:0] a, input logic [7:0] b, output logic [7:0] q,
                           output logic [7:0] r, output logic z, output int k, output int bc);
        @(negedge clk);
        start_op(w4, a, b);
        wait_done(w4, 0, q, r, z, k, bc);
    endtask

    task automatic check_op(input string tag, input bit w4, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q, r;
        logic       z;
        int         k, bc;
        int         w = w4 ? 4 : 8;
        run_div(w4, a, b, q, r, z, k, bc);
        chk($sformatf("%s %0d/%0d quot", tag, a, b), 32'(q), 32'(model_q(w, int'(a), int'(b))));
        chk($sformatf("%s %0d/%0d rem", tag, a, b), 32'(r), 32'(model_r(int'(a), int'(b))));
        chk($sformatf("%s %0d/%0d dbz", tag, a, b), 32'(z), 32'(b == 0));
        chk($sformatf("%s %0d/%0d latency", tag, a, b), 32'(k), (b == 0) ? 32'd0 : 32'(w));
    endtask

    initial begin
        vec_t       tbl[7];
        logic [7:0] q, r, a, b;
        logic       z;
        int         k, bc, saw;

        tbl[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  z: 1'b0};
        tbl[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  z: 1'b0};
        tbl[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  z: 1'b0};
        tbl[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  z: 1'b0};
        tbl[4] = '{a: 8'd77,  b: 8'd0,   q: 8'd255, r: 8'd77, z: 1'b1};
        tbl[5] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,  z: 1'b0};
        tbl[6] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,  z: 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; dvd8 = '0; dvs8 = '0;
        start4 = 1'b0; dvd4 = '0; dvs4 = '0;
        repeat (2) @(negedge clk);
        chk("reset busy/done/dbz", {29'b0, busy8, done8, dbz8}, 32'd0);
        chk("reset quot/rem", {16'b0, quot8, rem8}, 32'd0);
        rst_n = 1'b1;

        // Fixed vectors: zero-divisor results appear the cycle after the sampling edge, without busy.
        for (int i = 0; i < 7; i++) begin
            run_div(1'b0, tbl[i].a, tbl[i].b, q, r, z, k, bc);
            chk($sformatf("vec%0d quot", i), 32'(q), 32'(tbl[i].q));
            chk($sformatf("vec%0d rem", i), 32'(r), 32'(tbl[i].r));
            chk($sformatf("vec%0d dbz", i), 32'(z), 32'(tbl[i].z));
            chk($sformatf("vec%0d latency", i), 32'(k), tbl[i].z ? 32'd0 : 32'd8);
            chk($sformatf("vec%0d busy cycles", i), 32'(bc), tbl[i].z ? 32'd0 : 32'd8);
            chk($sformatf("vec%0d busy low at done", i), 32'(busy8), 32'd0);
        end

        @(negedge clk);
        chk("done is a single pulse", 32'(done8), 32'd0);

        // Start held during RUN must not re-sample operands.
        start_op(1'b0, 8'd100, 8'd3);
        start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5;
        repeat (4) @(negedge clk);
        start8 = 1'b0;
        wait_done(1'b0, 4, q, r, z, k, bc);
        chk("ignore-start quot", 32'(q), 32'd33);
        chk("ignore-start rem", 32'(r), 32'd1);
        chk("ignore-start latency", 32'(k), 32'd8);
        // Back-to-back: start accepted in the done cycle.
        start_op(1'b0, 8'd50, 8'd5);
        wait_done(1'b0, 0, q, r, z, k, bc);
        chk("back-to-back quot", 32'(q), 32'd10);
        chk("back-to-back rem", 32'(r), 32'd0);
        chk("back-to-back latency", 32'(k), 32'd8);

        // Asynchronous abort in the middle of a RUN.
        @(negedge clk);
        start_op(1'b0, 8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort busy/done/dbz", {29'b0, busy8, done8, dbz8}, 32'd0);
        chk("abort quot/rem", {16'b0, quot8, rem8}, 32'd0);
        saw = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) saw++;
        end
        chk("no activity after abort", 32'(saw), 32'd0);
        check_op("post-abort", 1'b0, 8'd13, 8'd4);

        for (int i = 0; i < 150; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            check_op("rand8", 1'b0, a, b);
        end

        for (int i = 0; i < 256; i++) check_op("exh4", 1'b1, 8'(i >> 4), 8'(i & 15));

        chk("quot/rem stable while busy", 32'(stab_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
